div: RTL and testbench

- Multi-cycle 32-bit radix-2 restoring divider serving the execute stage for DIV/DIVU.
- The execute stage raises start_i and holds its stall request while ready_o is low.
- On ready_o, the execute stage forwards {remainder, quotient} as hi/lo toward the EX/MEM register with whilo set.
- annul_i lets the execute stage abandon an in-flight division, e.g. on flush.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div.sv | 138 +++++++++++++
 tb/tb_div.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the multi-cycle restoring divider.
package div_pkg;

  localparam logic        RstEnable         = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Two's-complement magnitude when neg is set, identity otherwise.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// 32-bit radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// result held as {remainder, quotient} until the requester drops start_i.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic        ready_d;
  logic [63:0] result_d;

  logic        op1_neg, op2_neg;
  logic [32:0] temp;

  assign op1_neg = signed_div_i & opdata1_i[31];
  assign op2_neg = signed_div_i & opdata2_i[31];

  // Trial subtract of the divisor from the current partial remainder.
  assign temp = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    ready_d    = ready_o;
    result_d   = result_o;

    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = {ZeroWord, ZeroWord};
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            signed_d   = signed_div_i;
            neg1_d     = op1_neg;
            neg2_d     = op2_neg;
            dividend_d = {32'b0, magnitude(opdata1_i, op1_neg), 1'b0};
            divisor_d  = magnitude(opdata2_i, op2_neg);
            cnt_d      = 6'd0;
            state_d    = DivOn;
          end
        end
      end

      DivByZero: begin
        dividend_d = '0;
        state_d    = DivEnd;
      end

      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = 6'd0;
        end else if (cnt_q < 6'd32) begin
          if (temp[32]) begin
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            dividend_d = {temp[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          // Restore signs: quotient negative when operand signs differ,
          // remainder takes the dividend's sign.
          if (signed_q && (neg1_q ^ neg2_q)) begin
            dividend_d[31:0] = ~dividend_q[31:0] + 32'd1;
          end
          if (signed_q && neg1_q) begin
            dividend_d[64:33] = ~dividend_q[64:33] + 32'd1;
          end
          state_d = DivEnd;
          cnt_d   = 6'd0;
        end
      end

      DivEnd: begin
        ready_d  = DivResultReady;
        result_d = {dividend_q[64:33], dividend_q[31:0]};
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end
      end

      default: state_d = DivFree;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= DivFree;
      cnt_q    <= 6'd0;
      ready_o  <= DivResultNotReady;
      result_o <= {ZeroWord, ZeroWord};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_o  <= ready_d;
      result_o <= result_d;
    end
  end

  // NOTE: the work registers are deliberately left out of reset; they are
  // always reloaded at acceptance before anything reads them.
  always_ff @(posedge clk) begin
    dividend_q <= dividend_d;
    divisor_q  <= divisor_d;
    signed_q   <= signed_d;
    neg1_q     <= neg1_d;
    neg2_q     <= neg2_d;
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: table of directed divisions plus hand-written
// annul, reset-mid-operation and operand-change sequences.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests = 0;
  int fails = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Latency counts rising edges after the acceptance edge E0 until ready_o is seen.
  task automatic run_div(input string nm, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input bit scramble);
    int n;
    logic seen;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (scramble && i == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        seen = 1'b1;
        n    = i;
        break;
      end
    end
    if (!seen) n = 101;
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " result"}, result_o, exp);
    @(posedge clk);
    #1;
    check({nm, " held ready"}, {63'b0, ready_o}, 64'd1);
    check({nm, " held result"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({nm, " release ready"}, {63'b0, ready_o}, 64'd0);
    check({nm, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_ready;

    vecs[0]  = '{"udiv 100/7",        1'b0, 32'd100,       32'd7,         {32'd2,          32'd14},          34};
    vecs[1]  = '{"sdiv -7/2",         1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF,  32'hFFFF_FFFD},  34};
    vecs[2]  = '{"sdiv 7/-2",         1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001,  32'hFFFF_FFFD},  34};
    vecs[3]  = '{"sdiv -100/-7",      1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE,  32'h0000_000E},  34};
    vecs[4]  = '{"udiv 5/9",          1'b0, 32'd5,         32'd9,         {32'd5,          32'd0},          34};
    vecs[5]  = '{"udiv by zero",      1'b0, 32'h0000_1234, 32'd0,         64'd0,                             2};
    vecs[6]  = '{"sdiv by zero",      1'b1, 32'hFFFF_FFFB, 32'd0,         64'd0,                             2};
    vecs[7]  = '{"sdiv overflow",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,          32'h8000_0000},  34};
    vecs[8]  = '{"udiv max/1",        1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0,          32'hFFFF_FFFF},  34};
    vecs[9]  = '{"udiv 8000_0000/max",1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000,  32'd0},          34};
    vecs[10] = '{"udiv max/max",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0,          32'd1},          34};
    vecs[11] = '{"sdiv -1/1",         1'b1, 32'hFFFF_FFFF, 32'd1,         {32'd0,          32'hFFFF_FFFF},  34};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {63'b0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Consecutive entries are back-to-back: start drops for exactly one cycle.
    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);
    end

    // Annul one cycle during iteration 10; start drops with it so no re-accept.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen_ready = 1'b1;
    end
    check("annul no ready", {63'b0, seen_ready}, 64'd0);
    check("annul result idle", result_o, 64'd0);
    run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 1'b0);

    // Synchronous reset at iteration 20 must kill the in-flight division.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midop reset ready", {63'b0, ready_o}, 64'd0);
    check("midop reset result", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen_ready = 1'b1;
    end
    check("midop reset no ready", {63'b0, seen_ready}, 64'd0);

    // Operands change right after acceptance; the latched values must win.
    run_div("scrambled 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 34, 1'b1);
    run_div("scrambled -9/4", 1'b1, 32'hFFFF_FFF7, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 34, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
